// File: rtl/sram_responder_pkg.sv
// Shared constants and strobe-merge helpers for the SRAM responder and its MMIO block.
package sram_responder_pkg;

  localparam int          DATA_W           = 32;
  localparam int          ADDR_W           = 32;
  localparam int          LED_W            = 16;
  localparam int          DEPTH_LOG2_DEF   = 14;
  localparam logic [15:0] MMIO_BASE_HI_DEF = 16'hBFAF;

  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_RDCNT   = 16'hE010;
  localparam logic [15:0] OFF_WRCNT   = 16'hE014;
  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SCRATCH = 16'hF010;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [3:0]        strb);
    logic [DATA_W-1:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [LED_W-1:0] merge_led(input logic [LED_W-1:0] old_val,
                                                 input logic [LED_W-1:0] new_val,
                                                 input logic [1:0]       strb);
    logic [LED_W-1:0] res;
    for (int i = 0; i < 2; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_resp_mmio.sv
// MMIO register file: free-running timer, LED, scratch and (with SRAM_RESP_STATS_EN)
// memory read/write counters. Read data is combinational; the top registers it.
module sram_resp_mmio
  import sram_responder_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              sel,
  input  logic [3:0]        we,
  input  logic [15:0]       offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [DATA_W-1:0] rdata,
  output logic [LED_W-1:0]  led
);

  logic              wr_s;
  logic [DATA_W-1:0] timer_r;
  logic [DATA_W-1:0] scratch_r;
  logic [LED_W-1:0]  led_r;

  assign wr_s = sel && (we != 4'b0000);

  // A timer write replaces that cycle's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_r <= 32'd0;
    end else if (wr_s && (offset == OFF_TIMER)) begin
      timer_r <= merge_bytes(timer_r, wdata, we);
    end else begin
      timer_r <= timer_r + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_r     <= 16'd0;
      scratch_r <= 32'd0;
    end else begin
      if (wr_s && (offset == OFF_LED)) begin
        led_r <= merge_led(led_r, wdata[LED_W-1:0], we[1:0]);
      end
      if (wr_s && (offset == OFF_SCRATCH)) begin
        scratch_r <= merge_bytes(scratch_r, wdata, we);
      end
    end
  end

`ifdef SRAM_RESP_STATS_EN
  logic [DATA_W-1:0] rdcnt_r;
  logic [DATA_W-1:0] wrcnt_r;

  // Counter clear takes priority over a same-cycle count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdcnt_r <= 32'd0;
      wrcnt_r <= 32'd0;
    end else begin
      if (wr_s && (offset == OFF_RDCNT)) begin
        rdcnt_r <= 32'd0;
      end else if (mem_rd) begin
        rdcnt_r <= rdcnt_r + 32'd1;
      end
      if (wr_s && (offset == OFF_WRCNT)) begin
        wrcnt_r <= 32'd0;
      end else if (mem_wr) begin
        wrcnt_r <= wrcnt_r + 32'd1;
      end
    end
  end
`else
  logic unused_stats_s;
  assign unused_stats_s = mem_rd ^ mem_wr;
`endif

  always_comb begin
    rdata = 32'd0;
    case (offset)
      OFF_TIMER:   rdata = timer_r;
      OFF_LED:     rdata = {16'd0, led_r};
      OFF_SCRATCH: rdata = scratch_r;
`ifdef SRAM_RESP_STATS_EN
      OFF_RDCNT:   rdata = rdcnt_r;
      OFF_WRCNT:   rdata = wrcnt_r;
`endif
      default:     rdata = 32'd0;
    endcase
  end

  assign led = led_r;

endmodule

// File: rtl/sram_responder.sv
// Unified on-chip SRAM with read-only inst port and read/write data port plus MMIO window.
// Optional statistics counters are enabled by defining SRAM_RESP_STATS_EN.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2   = DEPTH_LOG2_DEF,
  parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_we,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_we,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic [LED_W-1:0]  led
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_r [WORDS];
  logic [DEPTH_LOG2-1:0] inst_idx_s;
  logic [DEPTH_LOG2-1:0] data_idx_s;
  logic                  is_mmio_s;
  logic                  mmio_sel_s;
  logic                  mem_rd_s;
  logic                  mem_wr_s;
  logic [DATA_W-1:0]     mmio_rdata_s;
  logic                  unused_s;

  assign inst_idx_s = inst_sram_addr[DEPTH_LOG2+1:2];
  assign data_idx_s = data_sram_addr[DEPTH_LOG2+1:2];
  assign is_mmio_s  = (data_sram_addr[31:16] == MMIO_BASE_HI);
  assign mmio_sel_s = data_sram_en && is_mmio_s;
  assign mem_rd_s   = data_sram_en && !is_mmio_s && (data_sram_we == 4'b0000);
  assign mem_wr_s   = data_sram_en && !is_mmio_s && (data_sram_we != 4'b0000);

  assign unused_s = ^{inst_sram_we, inst_sram_wdata, inst_sram_addr[ADDR_W-1:DEPTH_LOG2+2],
                      inst_sram_addr[1:0], data_sram_addr[1:0]};

  // Array is not reset; gating on resetn drops a write coinciding with reset.
  always_ff @(posedge clk) begin
    if (resetn && mem_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem_r[data_idx_s][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read-first: both ports sample the array before the same-edge write lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_sram_rdata <= 32'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      if (inst_sram_en) begin
        inst_sram_rdata <= mem_r[inst_idx_s];
      end
      if (data_sram_en) begin
        data_sram_rdata <= is_mmio_s ? mmio_rdata_s : mem_r[data_idx_s];
      end
    end
  end

  sram_resp_mmio u_mmio (
    .clk    (clk),
    .resetn (resetn),
    .sel    (mmio_sel_s),
    .we     (data_sram_we),
    .offset (data_sram_addr[15:0]),
    .wdata  (data_sram_wdata),
    .mem_rd (mem_rd_s),
    .mem_wr (mem_wr_s),
    .rdata  (mmio_rdata_s),
    .led    (led)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder; stats checks follow SRAM_RESP_STATS_EN.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;

  int vectors = 0;
  int miscompares = 0;

  sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    inst_sram_en    = 1'b0;
    inst_sram_we    = 4'b0000;
    inst_sram_addr  = 32'd0;
    inst_sram_wdata = 32'd0;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'b0000;
    data_sram_addr  = 32'd0;
    data_sram_wdata = 32'd0;
  endtask

  task automatic dwrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
    data_sram_en    = 1'b1;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    step();
    data_sram_en    = 1'b0;
    data_sram_we    = 4'b0000;
  endtask

  task automatic dread(input logic [31:0] addr);
    data_sram_en   = 1'b1;
    data_sram_we   = 4'b0000;
    data_sram_addr = addr;
    step();
    data_sram_en   = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_idle();
    step();
    step();
    vectors++;
    if (inst_sram_rdata !== 32'd0 || data_sram_rdata !== 32'd0 || led !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_initial: inst=%h data=%h led=%h required all 0",
               inst_sram_rdata, data_sram_rdata, led);
    end
    resetn = 1'b1;
    dwrite(32'h0000_0000, 32'h1C00_0000, 4'b1111);
    dwrite(32'hBFAF_F000, 32'h0000_BEEF, 4'b1111);
    vectors++;
    if (led !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL led_before_reset: got %h required %h", led, 16'hBEEF);
    end
    dread(32'h0000_0000);
    resetn = 1'b0;
    #1;
    vectors++;
    if (inst_sram_rdata !== 32'd0 || data_sram_rdata !== 32'd0 || led !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_async: inst=%h data=%h led=%h required all 0",
               inst_sram_rdata, data_sram_rdata, led);
    end
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0000_0000;
    dwrite(32'h0000_0000, 32'h0000_0000, 4'b1111);
    vectors++;
    if (inst_sram_rdata !== 32'd0 || data_sram_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_hold: inst=%h data=%h required 0", inst_sram_rdata, data_sram_rdata);
    end
    resetn = 1'b1;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0000_0000;
    data_sram_en   = 1'b1;
    data_sram_we   = 4'b0000;
    data_sram_addr = 32'hBFAF_E000;
    #2;
    vectors++;
    if (inst_sram_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL inst_latency_early: got %h required 0", inst_sram_rdata);
    end
    step();
    set_idle();
    vectors++;
    if (inst_sram_rdata !== 32'h1C00_0000) begin
      miscompares++;
      $display("FAIL inst_first_read: got %h required %h", inst_sram_rdata, 32'h1C00_0000);
    end
    vectors++;
    if (data_sram_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL timer_after_reset: got %h required 0", data_sram_rdata);
    end
    dread(32'hBFAF_E000);
    vectors++;
    if (data_sram_rdata !== 32'd1) begin
      miscompares++;
      $display("FAIL timer_second_read: got %h required 1", data_sram_rdata);
    end
  endtask

  task automatic test_byte_strobes();
    dwrite(32'h0000_0100, 32'hAABB_CCDD, 4'b1111);
    dwrite(32'h0000_0100, 32'h1122_3344, 4'b0101);
    vectors++;
    if (data_sram_rdata !== 32'hAABB_CCDD) begin
      miscompares++;
      $display("FAIL write_returns_old: got %h required %h", data_sram_rdata, 32'hAABB_CCDD);
    end
    dread(32'h0000_0100);
    vectors++;
    if (data_sram_rdata !== 32'hAA22_CC44) begin
      miscompares++;
      $display("FAIL byte_strobe_merge: got %h required %h", data_sram_rdata, 32'hAA22_CC44);
    end
    dread(32'h0001_0103);
    vectors++;
    if (data_sram_rdata !== 32'hAA22_CC44) begin
      miscompares++;
      $display("FAIL address_alias: got %h required %h", data_sram_rdata, 32'hAA22_CC44);
    end
    data_sram_en    = 1'b0;
    data_sram_we    = 4'b1111;
    data_sram_addr  = 32'h0000_0100;
    data_sram_wdata = 32'h0;
    step();
    set_idle();
    dread(32'h0000_0100);
    vectors++;
    if (data_sram_rdata !== 32'hAA22_CC44) begin
      miscompares++;
      $display("FAIL write_without_en: got %h required %h", data_sram_rdata, 32'hAA22_CC44);
    end
  endtask

  task automatic test_read_during_write();
    dwrite(32'h0000_0200, 32'h0000_0009, 4'b1111);
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0000_0200;
    dwrite(32'h0000_0200, 32'h0000_0005, 4'b1111);
    vectors++;
    if (inst_sram_rdata !== 32'h9 || data_sram_rdata !== 32'h9) begin
      miscompares++;
      $display("FAIL rdw_old_word: inst=%h data=%h required 9", inst_sram_rdata, data_sram_rdata);
    end
    step();
    inst_sram_en = 1'b0;
    vectors++;
    if (inst_sram_rdata !== 32'h5) begin
      miscompares++;
      $display("FAIL rdw_new_word: got %h required 5", inst_sram_rdata);
    end
    inst_sram_addr = 32'h0000_0100;
    step();
    vectors++;
    if (inst_sram_rdata !== 32'h5) begin
      miscompares++;
      $display("FAIL rdata_hold: got %h required 5", inst_sram_rdata);
    end
    inst_sram_en    = 1'b1;
    inst_sram_we    = 4'b1111;
    inst_sram_wdata = 32'h0;
    step();
    set_idle();
    dread(32'h0000_0100);
    vectors++;
    if (data_sram_rdata !== 32'hAA22_CC44) begin
      miscompares++;
      $display("FAIL inst_port_no_write: got %h required %h", data_sram_rdata, 32'hAA22_CC44);
    end
    dwrite(32'hBFAF_0100, 32'hDEAD_BEEF, 4'b1111);
    dread(32'h0000_0100);
    vectors++;
    if (data_sram_rdata !== 32'hAA22_CC44) begin
      miscompares++;
      $display("FAIL mmio_no_array_write: got %h required %h", data_sram_rdata, 32'hAA22_CC44);
    end
  endtask

  task automatic test_timer();
    dwrite(32'hBFAF_E000, 32'hFFFF_FFFE, 4'b1111);
    step();
    dread(32'hBFAF_E000);
    vectors++;
    if (data_sram_rdata !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL timer_load: got %h required %h", data_sram_rdata, 32'hFFFF_FFFF);
    end
    dread(32'hBFAF_E000);
    vectors++;
    if (data_sram_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL timer_wrap: got %h required 0", data_sram_rdata);
    end
    data_sram_en    = 1'b0;
    data_sram_we    = 4'b1111;
    data_sram_addr  = 32'hBFAF_E000;
    data_sram_wdata = 32'h0;
    step();
    set_idle();
    dread(32'hBFAF_E000);
    vectors++;
    if (data_sram_rdata !== 32'h2) begin
      miscompares++;
      $display("FAIL timer_en0_write: got %h required 2", data_sram_rdata);
    end
  endtask

  task automatic test_led_scratch();
    dwrite(32'hBFAF_F000, 32'h1234_5678, 4'b1111);
    vectors++;
    if (led !== 16'h5678) begin
      miscompares++;
      $display("FAIL led_write: got %h required %h", led, 16'h5678);
    end
    dread(32'hBFAF_F000);
    vectors++;
    if (data_sram_rdata !== 32'h0000_5678) begin
      miscompares++;
      $display("FAIL led_readback: got %h required %h", data_sram_rdata, 32'h0000_5678);
    end
    dwrite(32'hBFAF_F000, 32'hFFFF_FFFF, 4'b1100);
    vectors++;
    if (led !== 16'h5678) begin
      miscompares++;
      $display("FAIL led_upper_strobes: got %h required %h", led, 16'h5678);
    end
    dread(32'hBFAF_F004);
    vectors++;
    if (data_sram_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL unmapped_offset: got %h required 0", data_sram_rdata);
    end
    dwrite(32'hBFAF_F010, 32'hFF00_0000, 4'b1000);
    vectors++;
    if (data_sram_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL scratch_old_on_write: got %h required 0", data_sram_rdata);
    end
    dread(32'hBFAF_F010);
    vectors++;
    if (data_sram_rdata !== 32'hFF00_0000) begin
      miscompares++;
      $display("FAIL scratch_strobe_hi: got %h required %h", data_sram_rdata, 32'hFF00_0000);
    end
    dwrite(32'hBFAF_F010, 32'h00AB_00CD, 4'b0001);
    vectors++;
    if (data_sram_rdata !== 32'hFF00_0000) begin
      miscompares++;
      $display("FAIL mmio_rdw_old: got %h required %h", data_sram_rdata, 32'hFF00_0000);
    end
    dread(32'hBFAF_F010);
    vectors++;
    if (data_sram_rdata !== 32'hFF00_00CD) begin
      miscompares++;
      $display("FAIL scratch_strobe_lo: got %h required %h", data_sram_rdata, 32'hFF00_00CD);
    end
  endtask

  task automatic test_stats();
`ifdef SRAM_RESP_STATS_EN
    dwrite(32'hBFAF_E010, 32'h0, 4'b1111);
    dwrite(32'hBFAF_E014, 32'h0, 4'b0001);
    dread(32'h0000_0000);
    dread(32'h0000_0004);
    dread(32'h0000_0100);
    dwrite(32'h0000_0300, 32'h1, 4'b1111);
    dwrite(32'h0000_0304, 32'h2, 4'b0010);
    dread(32'hBFAF_E000);
    dread(32'hBFAF_E010);
    vectors++;
    if (data_sram_rdata !== 32'd3) begin
      miscompares++;
      $display("FAIL rdcnt: got %h required 3", data_sram_rdata);
    end
    dread(32'hBFAF_E014);
    vectors++;
    if (data_sram_rdata !== 32'd2) begin
      miscompares++;
      $display("FAIL wrcnt: got %h required 2", data_sram_rdata);
    end
    dwrite(32'hBFAF_E010, 32'h0, 4'b0100);
    dread(32'hBFAF_E010);
    vectors++;
    if (data_sram_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rdcnt_clear: got %h required 0", data_sram_rdata);
    end
    dread(32'hBFAF_E014);
    vectors++;
    if (data_sram_rdata !== 32'd2) begin
      miscompares++;
      $display("FAIL wrcnt_after_rd_clear: got %h required 2", data_sram_rdata);
    end
`else
    dread(32'h0000_0000);
    dwrite(32'h0000_0300, 32'h1, 4'b1111);
    dwrite(32'hBFAF_E010, 32'hFFFF_FFFF, 4'b1111);
    dread(32'hBFAF_E010);
    vectors++;
    if (data_sram_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rdcnt_absent: got %h required 0", data_sram_rdata);
    end
    dread(32'hBFAF_E014);
    vectors++;
    if (data_sram_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL wrcnt_absent: got %h required 0", data_sram_rdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_byte_strobes();
    test_read_during_write();
    test_timer();
    test_led_scratch();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Responder end of the core's inst/data SRAM interfaces. Used as on-chip memory plus a small MMIO register file for bring-up and simulation.
- A single unified word array serves both ports: the inst port is read-only, the data port is read/write with byte enables.
- The data port decodes an MMIO window holding a free-running timer, an LED register and a scratch register.
- Sits directly below the CPU top and replaces the external SRAM models.

Parameters:
- DEPTH_LOG2, 14, log2 of the word count; array holds 2^DEPTH_LOG2 32-bit words (64 KiB default).
- MMIO_BASE_HI, 16'hBFAF, data-port address bits [31:16] that select the MMIO window.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- inst_sram_en  input  1  inst read request
- inst_sram_we  input  4  ignored; inst port never writes
- inst_sram_addr  input  32  inst byte address
- inst_sram_wdata  input  32  ignored
- inst_sram_rdata  output  32  inst read data, one cycle after the request
- data_sram_en  input  1  data request
- data_sram_we  input  4  byte write strobes; 4'b0000 with en=1 is a read
- data_sram_addr  input  32  data byte address
- data_sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i]
- data_sram_rdata  output  32  data read data, one cycle after the request
- led  output  16  LED register contents

Behaviour:
- Clock and reset: single clock `clk`. Reset is asynchronous and active-low on `resetn`.
- Reset values: inst_sram_rdata=0, data_sram_rdata=0, led=0, timer=0, scratch=0. The memory array is not reset.
- Latency: fixed 1 cycle, no stall or ready. A request at edge N has its rdata valid after edge N+1. The rdata registers hold their last value while en=0.
- Memory index: addr[DEPTH_LOG2+1:2]. Upper bits alias and addr[1:0] is ignored (word-aligned response). The CPU performs lane selection for sub-word loads.
- Data-port decode:
  - addr[31:16]==MMIO_BASE_HI selects MMIO; any other address selects memory.
  - MMIO accesses never touch the array.
- Inst port: always reads the array, with no MMIO decode.
- Writes: a write requires en=1. A nonzero we with en=0 is ignored. Each set strobe bit writes only its byte lane.
- Read-during-write:
  - A data write returns the old word on data_sram_rdata (read-first).
  - If the inst port reads the same word in the same cycle, it also returns the old word. The new word is visible from the next request onward.
- MMIO map (offset = addr[15:0]):
  - 0xE000 TIMER: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF to 0. A read returns the value at the request edge. A write with any strobe loads the strobed bytes; the write wins over that cycle's increment, and increment resumes on the next cycle.
  - 0xF000 LED: RW, bits [15:0] only. Strobes 0 and 1 apply. Reads return {16'b0, led}.
  - 0xF010 SCRATCH: RW 32-bit, byte strobes apply.
  - Any other offset reads 0 and ignores writes.
- An MMIO read in the same cycle as a write to the same register returns the old value.
- Reset asserted mid-operation: all registers clear immediately. The array keeps its contents, and any write in flight on the asserting edge is dropped.

Optional Feature:
- Macro: SRAM_RESP_STATS_EN.
- When defined:
  - Adds two 32-bit counters that reset to 0 and wrap.
  - 0xE010 RDCNT: counts data-port reads (en=1, we=0) to memory.
  - 0xE014 WRCNT: counts data-port writes (en=1, we!=0) to memory.
  - MMIO accesses are not counted.
  - Writing either counter with any strobe clears it. The clear wins over a same-cycle count.
- When undefined: 0xE010 and 0xE014 read 0 and writes are ignored. No counter flops exist.

Decomposition:
- Shared package: MMIO offsets (TIMER, LED, SCRATCH, RDCNT, WRCNT), MMIO_BASE_HI default, LED width, data/addr width constants.
- Natural sub-module: sram_resp_mmio. It holds the timer, LED, scratch and stats registers, strobe merge and read mux.
- The top holds the array, the port decode and the rdata registers.

Test Plan:
- Reset, then inst read of word 0 after preloading 0x1C000000 at index 0: inst_sram_rdata=0x1C000000 exactly one cycle later; all outputs are 0 during reset.
- Byte strobes: write 0xAABBCCDD with we=4'b1111 to 0x00000100, then 0x11223344 with we=4'b0101, then read: 0xAA22CC44.
- Read-during-write: data write 0x5 to 0x200 while inst reads 0x200 (old value 0x9): both rdata return 0x9 that cycle; the next inst read returns 0x5.
- Timer:
  - Write 0xFFFFFFFE to 0xBFAFE000, then read on the following cycles: 0xFFFFFFFF, 0x00000000 (wrap).
  - An en=0, we=4'b1111 cycle leaves the timer counting.
- LED/scratch:
  - Write 0x12345678 to 0xBFAFF000: led=0x5678 and readback is 0x00005678.
  - Read of offset 0xF004 is 0.
  - Scratch strobe 4'b1000 with 0xFF000000 over 0 gives 0xFF000000.
- With SRAM_RESP_STATS_EN: 3 memory reads, 2 memory writes and 1 MMIO read, then RDCNT=3 and WRCNT=2. Writing 0xBFAFE010 clears RDCNT to 0. Without the macro, both read 0.
